// File: rtl/crc_result_streamer_if.sv
// rtl/crc_result_streamer_if.sv - byte stream bundle between the CRC result streamer and its consumer
//
// Signals:
//   out_valid  producer -> consumer  out_data/out_index hold a valid byte
//   out_ready  consumer -> producer  byte accepted this cycle when out_valid is high
//   out_data   producer -> consumer  current result byte
//   out_index  producer -> consumer  position of the byte in transfer order
// Modports: master = producer (streamer), slave = consumer.

interface crc_result_streamer_if;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_index;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/crc_result_streamer.sv
// rtl/crc_result_streamer.sv - captures a finished CRC and streams it out one byte per handshake
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset, overrides every other input
//   load       capture crc/bitwidth and start a stream (IDLE only)
//   crc        finished CRC value, BITWIDTH bits
//   bitwidth   active CRC width, 1..63 literal, 0 means 64
//   abort      drop the current stream, no done pulse
//   out_if     byte stream (out_valid/out_ready/out_data/out_index), master side
//   busy       stream in progress (STREAM or DONE)
//   done       one-cycle pulse after the last byte is accepted
//
// Build option: define CRC_STREAM_MSB_FIRST_EN to send the most significant
// byte first; out_index still counts 0..nbytes-1 in transfer order.

module crc_result_streamer #(
    parameter int BITWIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [BITWIDTH-1:0]      crc,
    input  logic [5:0]               bitwidth,
    input  logic                     abort,
    crc_result_streamer_if.master    out_if,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Highest byte index the captured register can hold.
    localparam logic [2:0] MAX_LAST = 3'(BITWIDTH / 8 - 1);

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] value_q, value_d;
    // Index of the final byte (nbytes-1); storing it this way keeps it in 3 bits.
    logic [2:0]          last_q,  last_d;
    logic [2:0]          idx_q,   idx_d;

    // ------------------------------------------------------------------
    // Width decode.
    // bitwidth-1 in 6 bits wraps 0 to 63, which is exactly w-1 for every
    // legal encoding (0 means 64), so one subtraction covers both cases.
    // ------------------------------------------------------------------
    logic [5:0]  w_minus1;
    logic [63:0] mask64;
    logic [2:0]  last_dec;

    always_comb begin
        w_minus1 = bitwidth - 6'd1;
        // Bits 0..w-1 set; the extra shift by one keeps w=64 free of a 64-bit shift.
        mask64   = ~((~64'd0 << w_minus1) << 1);
        // (w+7)>>3 - 1 == (w-1)>>3; clamp so a narrow build never indexes past its register.
        last_dec = (w_minus1[5:3] > MAX_LAST) ? MAX_LAST : w_minus1[5:3];
    end

    // ------------------------------------------------------------------
    // Byte selection from the captured value.
    // ------------------------------------------------------------------
    logic [63:0] value64;
    logic [2:0]  byte_sel;
    logic [7:0]  cur_byte;

    always_comb begin
        value64                 = '0;
        value64[BITWIDTH-1:0]   = value_q;
`ifdef CRC_STREAM_MSB_FIRST_EN
        // idx never exceeds last, so this cannot underflow.
        byte_sel = last_q - idx_q;
`else
        byte_sel = idx_q;
`endif
        cur_byte = 8'(value64 >> {byte_sel, 3'b000});
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    logic       out_valid_c;
    logic [7:0] out_data_c;
    logic [2:0] out_index_c;
    logic       busy_c;
    logic       done_c;

    always_comb begin
        state_d     = state_q;
        value_d     = value_q;
        last_d      = last_q;
        idx_d       = idx_q;
        out_valid_c = 1'b0;
        out_data_c  = 8'd0;
        out_index_c = 3'd0;
        busy_c      = 1'b0;
        done_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort in the same cycle suppresses the load.
                if (load && !abort) begin
                    value_d = crc & mask64[BITWIDTH-1:0];
                    last_d  = last_dec;
                    idx_d   = 3'd0;
                    state_d = S_STREAM;
                end
            end

            S_STREAM: begin
                out_valid_c = 1'b1;
                busy_c      = 1'b1;
                out_index_c = idx_q;
                out_data_c  = cur_byte;
                // abort wins over a simultaneous handshake: that byte counts as unsent.
                if (abort) begin
                    idx_d   = 3'd0;
                    state_d = S_IDLE;
                end else if (out_if.out_ready) begin
                    if (idx_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end

            default: begin
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            value_q <= '0;
            last_q  <= 3'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
        end
    end

    assign out_if.out_valid = out_valid_c;
    assign out_if.out_data  = out_data_c;
    assign out_if.out_index = out_index_c;
    assign busy             = busy_c;
    assign done             = done_c;

endmodule
